// File: rtl/tdp_ram_pkg.sv
// Shared constants and the byte-lane merge helper for the tdp_ram_be_sc RAM.
package tdp_ram_pkg;

   localparam string RDW_WRITE_FIRST = "WRITE_FIRST";
   localparam string RDW_READ_FIRST  = "READ_FIRST";
   localparam string RDW_NO_CHANGE   = "NO_CHANGE";

   localparam int unsigned COLL_CNT_W = 16;

   // Merge helper works on a fixed maximum width; callers widen/narrow with casts.
   localparam int unsigned MERGE_MAX_W = 256;
   localparam int unsigned MERGE_IW    = $clog2(MERGE_MAX_W);

   typedef logic [MERGE_MAX_W-1:0] merge_word_t;

   function automatic merge_word_t merge_lanes(input merge_word_t old_w,
                                               input merge_word_t new_w,
                                               input merge_word_t lane_we,
                                               input int unsigned byte_w);
      merge_word_t res;
      res = old_w;
      for (int unsigned i = 0; i < MERGE_MAX_W; i++) begin
         if (lane_we[MERGE_IW'(i / byte_w)]) begin
            res[MERGE_IW'(i)] = new_w[MERGE_IW'(i)];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/tdp_ram_out_pipe.sv
// Data+valid output pipeline; the last stage only updates its data when valid arrives.
module tdp_ram_out_pipe
   import tdp_ram_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned STAGES = 1
)(
   input  logic              clka,
   input  logic              rstb,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_vld,
   output logic [DATA_W-1:0] o_data,
   output logic              o_vld
);

   if (STAGES == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = clka ^ rstb;
      assign o_data   = i_data;
      assign o_vld    = i_vld;
   end else begin : g_stages
      localparam int unsigned SW = (STAGES > 1) ? $clog2(STAGES) : 1;

      logic [DATA_W-1:0] r_data [STAGES];
      logic [STAGES-1:0] r_vld;
      logic [DATA_W-1:0] w_src_data [STAGES];
      logic [STAGES-1:0] w_src_vld;

      always_comb begin
         w_src_data[0] = i_data;
         w_src_vld[0]  = i_vld;
         for (int unsigned s = 1; s < STAGES; s++) begin
            w_src_data[SW'(s)] = r_data[SW'(s - 1)];
            w_src_vld[SW'(s)]  = r_vld[SW'(s - 1)];
         end
      end

      // Inner stages load every cycle; the output stage holds until valid data arrives.
      always_ff @(posedge clka) begin
         if (rstb) begin
            r_vld <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
               r_data[SW'(s)] <= '0;
            end
         end else begin
            r_vld <= w_src_vld;
            for (int unsigned s = 0; s < STAGES; s++) begin
               if ((s != STAGES - 1) || w_src_vld[SW'(s)]) begin
                  r_data[SW'(s)] <= w_src_data[SW'(s)];
               end
            end
         end
      end

      assign o_data = r_data[SW'(STAGES - 1)];
      assign o_vld  = r_vld[SW'(STAGES - 1)];
   end

endmodule

// File: rtl/tdp_ram_be_sc.sv
// Single-clock true dual-port RAM with byte enables, RDW modes and output pipeline.
// Define TDP_COLL_CNT_EN to build the saturating same-address collision counter.
module tdp_ram_be_sc
   import tdp_ram_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned BYTE_W     = 8,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned OUT_STAGES = 1,
   parameter string       RDW_MODE   = "WRITE_FIRST",
   parameter string       INIT_FILE  = "",
   localparam int unsigned NB = DATA_W / BYTE_W,
   localparam int unsigned AW = $clog2(DEPTH)
)(
   input  logic                  clka,
   input  logic                  rstb,
   input  logic                  ena,
   input  logic                  enb,
   input  logic [NB-1:0]         wea,
   input  logic [NB-1:0]         web,
   input  logic [AW-1:0]         addra,
   input  logic [AW-1:0]         addrb,
   input  logic [DATA_W-1:0]     dina,
   input  logic [DATA_W-1:0]     dinb,
   output logic [DATA_W-1:0]     douta,
   output logic [DATA_W-1:0]     doutb,
   output logic                  dvalida,
   output logic                  dvalidb,
   output logic                  coll_o,
   output logic [COLL_CNT_W-1:0] coll_cnt_o
);

   localparam bit WR_FIRST = (RDW_MODE == RDW_WRITE_FIRST);
   localparam bit NO_CHG   = (RDW_MODE == RDW_NO_CHANGE);

   typedef logic [DATA_W-1:0] mem_t [DEPTH];

   function automatic mem_t load_init();
      mem_t m;
      m = '{default: '0};
      return m;
   endfunction

   mem_t r_mem = load_init();

   logic              w_a_in, w_b_in;
   logic              w_acc_a, w_acc_b;
   logic              w_wr_a, w_wr_b;
   logic              w_rd_a, w_rd_b;
   logic              w_coll;
   logic [DATA_W-1:0] w_old_a, w_old_b;
   logic [DATA_W-1:0] w_wa_word, w_wb_word, w_coll_word;
   logic [DATA_W-1:0] w_rd_word_a, w_rd_word_b;

   logic [DATA_W-1:0] r_rd_data_a, r_rd_data_b;
   logic              r_rd_vld_a, r_rd_vld_b;
   logic              r_coll;

   // Addresses past DEPTH only exist when DEPTH is not a power of two.
   if (DEPTH == (1 << AW)) begin : g_pow2
      assign w_a_in = 1'b1;
      assign w_b_in = 1'b1;
   end else begin : g_npow2
      assign w_a_in = (addra < AW'(DEPTH));
      assign w_b_in = (addrb < AW'(DEPTH));
   end

   assign w_acc_a = ena & ~rstb;
   assign w_acc_b = enb & ~rstb;
   assign w_wr_a  = w_acc_a & (|wea) & w_a_in;
   assign w_wr_b  = w_acc_b & (|web) & w_b_in;
   assign w_rd_a  = w_acc_a & ~(NO_CHG & (|wea));
   assign w_rd_b  = w_acc_b & ~(NO_CHG & (|web));
   assign w_coll  = w_wr_a & w_wr_b & (addra == addrb);

   assign w_old_a = w_a_in ? r_mem[addra] : '0;
   assign w_old_b = w_b_in ? r_mem[addrb] : '0;

   assign w_wa_word = DATA_W'(merge_lanes(MERGE_MAX_W'(w_old_a), MERGE_MAX_W'(dina),
                                          MERGE_MAX_W'(wea), BYTE_W));
   assign w_wb_word = DATA_W'(merge_lanes(MERGE_MAX_W'(w_old_b), MERGE_MAX_W'(dinb),
                                          MERGE_MAX_W'(web), BYTE_W));
   // On a collision B's lanes go in first, then A overlays so A wins shared lanes.
   assign w_coll_word = DATA_W'(merge_lanes(MERGE_MAX_W'(w_wb_word), MERGE_MAX_W'(dina),
                                            MERGE_MAX_W'(wea), BYTE_W));

   assign w_rd_word_a = !w_a_in ? '0 : (WR_FIRST ? w_wa_word : w_old_a);
   assign w_rd_word_b = !w_b_in ? '0 : (WR_FIRST ? w_wb_word : w_old_b);

   always_ff @(posedge clka) begin
      if (w_coll) begin
         r_mem[addra] <= w_coll_word;
      end else begin
         if (w_wr_a) r_mem[addra] <= w_wa_word;
         if (w_wr_b) r_mem[addrb] <= w_wb_word;
      end
   end

   // Array read register; with no extra stages it is dout and must hold on idle cycles.
   always_ff @(posedge clka) begin
      if (rstb) begin
         r_rd_data_a <= '0;
         r_rd_data_b <= '0;
         r_rd_vld_a  <= 1'b0;
         r_rd_vld_b  <= 1'b0;
      end else begin
         r_rd_vld_a <= w_rd_a;
         r_rd_vld_b <= w_rd_b;
         if (w_rd_a || (OUT_STAGES != 0)) r_rd_data_a <= w_rd_word_a;
         if (w_rd_b || (OUT_STAGES != 0)) r_rd_data_b <= w_rd_word_b;
      end
   end

   tdp_ram_out_pipe #(
      .DATA_W (DATA_W),
      .STAGES (OUT_STAGES)
   ) u_pipe_a (
      .clka   (clka),
      .rstb   (rstb),
      .i_data (r_rd_data_a),
      .i_vld  (r_rd_vld_a),
      .o_data (douta),
      .o_vld  (dvalida)
   );

   tdp_ram_out_pipe #(
      .DATA_W (DATA_W),
      .STAGES (OUT_STAGES)
   ) u_pipe_b (
      .clka   (clka),
      .rstb   (rstb),
      .i_data (r_rd_data_b),
      .i_vld  (r_rd_vld_b),
      .o_data (doutb),
      .o_vld  (dvalidb)
   );

   always_ff @(posedge clka) begin
      if (rstb) r_coll <= 1'b0;
      else      r_coll <= w_coll;
   end

   assign coll_o = r_coll;

`ifdef TDP_COLL_CNT_EN
   logic [COLL_CNT_W-1:0] r_coll_cnt;

   // Saturating event counter, moves on the same edge that raises coll_o.
   always_ff @(posedge clka) begin
      if (rstb) begin
         r_coll_cnt <= '0;
      end else if (w_coll && (r_coll_cnt != '1)) begin
         r_coll_cnt <= r_coll_cnt + COLL_CNT_W'(1);
      end
   end

   assign coll_cnt_o = r_coll_cnt;
`else
   assign coll_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tdp_ram_be_sc.sv
// Directed bench for tdp_ram_be_sc: vector table on a WRITE_FIRST instance plus RDW/reset sequences.
module tb_tdp_ram_be_sc;

`ifdef TDP_COLL_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clka = 1'b0;
   logic        rstb, ena, enb;
   logic [3:0]  wea, web;
   logic [9:0]  addra, addrb;
   logic [31:0] dina, dinb;

   logic [31:0] douta_wf, doutb_wf, douta_rf, douta_nc;
   logic        dva_wf, dvb_wf, dva_rf, dva_nc, coll_wf;
   logic [15:0] cnt_wf;
   logic [31:0] doutb_rf_unused, doutb_nc_unused;
   logic        dvb_rf_unused, dvb_nc_unused, coll_rf_unused, coll_nc_unused;
   logic [15:0] cnt_rf_unused, cnt_nc_unused;

   always #5 clka = ~clka;

   tdp_ram_be_sc #(.DEPTH(1000), .OUT_STAGES(1), .RDW_MODE("WRITE_FIRST")) u_wf (
      .clka(clka), .rstb(rstb), .ena(ena), .enb(enb), .wea(wea), .web(web),
      .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
      .douta(douta_wf), .doutb(doutb_wf), .dvalida(dva_wf), .dvalidb(dvb_wf),
      .coll_o(coll_wf), .coll_cnt_o(cnt_wf));

   tdp_ram_be_sc #(.DEPTH(1024), .OUT_STAGES(2), .RDW_MODE("READ_FIRST")) u_rf (
      .clka(clka), .rstb(rstb), .ena(ena), .enb(enb), .wea(wea), .web(web),
      .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
      .douta(douta_rf), .doutb(doutb_rf_unused), .dvalida(dva_rf), .dvalidb(dvb_rf_unused),
      .coll_o(coll_rf_unused), .coll_cnt_o(cnt_rf_unused));

   tdp_ram_be_sc #(.DEPTH(1024), .OUT_STAGES(0), .RDW_MODE("NO_CHANGE")) u_nc (
      .clka(clka), .rstb(rstb), .ena(ena), .enb(enb), .wea(wea), .web(web),
      .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
      .douta(douta_nc), .doutb(doutb_nc_unused), .dvalida(dva_nc), .dvalidb(dvb_nc_unused),
      .coll_o(coll_nc_unused), .coll_cnt_o(cnt_nc_unused));

   typedef struct {
      logic        rst;
      logic        ena;
      logic [3:0]  wea;
      logic [9:0]  adra;
      logic [31:0] dina;
      logic        enb;
      logic [3:0]  web;
      logic [9:0]  adrb;
      logic [31:0] dinb;
      logic [31:0] xa;
      logic        va;
      logic [31:0] xb;
      logic        vb;
      logic        xc;
      logic [15:0] xn;
   } vec_t;

   localparam int NV = 31;
   vec_t tbl [NV];

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;

   function automatic vec_t mk(input logic rst, input logic a_en, input logic [3:0] a_we,
                               input logic [9:0] a_ad, input logic [31:0] a_di,
                               input logic b_en, input logic [3:0] b_we,
                               input logic [9:0] b_ad, input logic [31:0] b_di,
                               input logic [31:0] xa, input logic va,
                               input logic [31:0] xb, input logic vb,
                               input logic xc, input logic [15:0] xn);
      vec_t v;
      v.rst = rst; v.ena = a_en; v.wea = a_we; v.adra = a_ad; v.dina = a_di;
      v.enb = b_en; v.web = b_we; v.adrb = b_ad; v.dinb = b_di;
      v.xa = xa; v.va = va; v.xb = xb; v.vb = vb; v.xc = xc; v.xn = xn;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic a_en, input logic [3:0] a_we,
                        input logic [9:0] a_ad, input logic [31:0] a_di,
                        input logic b_en, input logic [3:0] b_we,
                        input logic [9:0] b_ad, input logic [31:0] b_di);
      rstb = rst; ena = a_en; wea = a_we; addra = a_ad; dina = a_di;
      enb = b_en; web = b_we; addrb = b_ad; dinb = b_di;
   endtask

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      drive(1'b1, 0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd0, 32'h0);

      tbl[0]  = mk(1, 0, 4'h0, 10'd0,    32'h0,        0, 4'h0, 10'd0,    32'h0,        32'h0,        0, 32'h0,        0, 0, 16'd0);
      tbl[1]  = mk(1, 1, 4'hF, 10'd6,    32'h99,       0, 4'h0, 10'd0,    32'h0,        32'h0,        0, 32'h0,        0, 0, 16'd0);
      tbl[2]  = mk(0, 1, 4'hF, 10'd5,    32'hDEADBEEF, 0, 4'h0, 10'd0,    32'h0,        32'h0,        0, 32'h0,        0, 0, 16'd0);
      tbl[3]  = mk(0, 1, 4'h0, 10'd5,    32'h0,        0, 4'h0, 10'd0,    32'h0,        32'hDEADBEEF, 1, 32'h0,        0, 0, 16'd0);
      tbl[4]  = mk(0, 0, 4'h0, 10'd0,    32'h0,        0, 4'h0, 10'd0,    32'h0,        32'hDEADBEEF, 1, 32'h0,        0, 0, 16'd0);
      tbl[5]  = mk(0, 0, 4'h0, 10'd0,    32'h0,        0, 4'h0, 10'd0,    32'h0,        32'hDEADBEEF, 0, 32'h0,        0, 0, 16'd0);
      tbl[6]  = mk(0, 0, 4'h0, 10'd0,    32'h0,        1, 4'h0, 10'd6,    32'h0,        32'hDEADBEEF, 0, 32'h0,        0, 0, 16'd0);
      tbl[7]  = mk(0, 1, 4'hF, 10'd9,    32'h11223344, 0, 4'h0, 10'd0,    32'h0,        32'hDEADBEEF, 0, 32'h0,        1, 0, 16'd0);
      tbl[8]  = mk(0, 1, 4'h5, 10'd9,    32'hAABBCCDD, 0, 4'h0, 10'd0,    32'h0,        32'h11223344, 1, 32'h0,        0, 0, 16'd0);
      tbl[9]  = mk(0, 0, 4'h0, 10'd0,    32'h0,        1, 4'h0, 10'd9,    32'h0,        32'h11BB33DD, 1, 32'h0,        0, 0, 16'd0);
      tbl[10] = mk(0, 0, 4'h0, 10'd0,    32'h0,        0, 4'h0, 10'd0,    32'h0,        32'h11BB33DD, 0, 32'h11BB33DD, 1, 0, 16'd0);
      tbl[11] = mk(0, 0, 4'h0, 10'd0,    32'h0,        1, 4'hF, 10'd7,    32'h12345678, 32'h11BB33DD, 0, 32'h11BB33DD, 0, 0, 16'd0);
      tbl[12] = mk(0, 1, 4'hC, 10'd7,    32'hAAAAAAAA, 1, 4'h6, 10'd7,    32'hBBBBBBBB, 32'h11BB33DD, 0, 32'h12345678, 1, 1, 16'd1);
      tbl[13] = mk(0, 1, 4'h0, 10'd7,    32'h0,        0, 4'h0, 10'd0,    32'h0,        32'hAAAA5678, 1, 32'h12BBBB78, 1, 0, 16'd1);
      tbl[14] = mk(0, 0, 4'h0, 10'd0,    32'h0,        0, 4'h0, 10'd0,    32'h0,        32'hAAAABB78, 1, 32'h12BBBB78, 0, 0, 16'd1);
      tbl[15] = mk(0, 1, 4'hF, 10'd12,   32'h4,        0, 4'h0, 10'd0,    32'h0,        32'hAAAABB78, 0, 32'h12BBBB78, 0, 0, 16'd1);
      tbl[16] = mk(0, 1, 4'h0, 10'd12,   32'h0,        1, 4'hF, 10'd12,   32'h5,        32'h4,        1, 32'h12BBBB78, 0, 0, 16'd1);
      tbl[17] = mk(0, 1, 4'h0, 10'd12,   32'h0,        0, 4'h0, 10'd0,    32'h0,        32'h4,        1, 32'h5,        1, 0, 16'd1);
      tbl[18] = mk(0, 0, 4'h0, 10'd0,    32'h0,        0, 4'h0, 10'd0,    32'h0,        32'h5,        1, 32'h5,        0, 0, 16'd1);
      tbl[19] = mk(0, 1, 4'hF, 10'd1000, 32'hFFFFFFFF, 1, 4'hF, 10'd1000, 32'h1,        32'h5,        0, 32'h5,        0, 0, 16'd1);
      tbl[20] = mk(0, 1, 4'h0, 10'd1000, 32'h0,        0, 4'h0, 10'd0,    32'h0,        32'h0,        1, 32'h0,        1, 0, 16'd1);
      tbl[21] = mk(0, 1, 4'h0, 10'd999,  32'h0,        1, 4'h0, 10'd1000, 32'h0,        32'h0,        1, 32'h0,        0, 0, 16'd1);
      tbl[22] = mk(0, 0, 4'h0, 10'd0,    32'h0,        0, 4'h0, 10'd0,    32'h0,        32'h0,        1, 32'h0,        1, 0, 16'd1);
      tbl[23] = mk(0, 1, 4'hF, 10'd20,   32'h77,       1, 4'hF, 10'd21,   32'h88,       32'h0,        0, 32'h0,        0, 0, 16'd1);
      tbl[24] = mk(0, 1, 4'h0, 10'd21,   32'h0,        1, 4'h0, 10'd20,   32'h0,        32'h77,       1, 32'h88,       1, 0, 16'd1);
      tbl[25] = mk(0, 0, 4'h0, 10'd0,    32'h0,        0, 4'h0, 10'd0,    32'h0,        32'h88,       1, 32'h77,       1, 0, 16'd1);
      tbl[26] = mk(0, 1, 4'h1, 10'd30,   32'hA1,       1, 4'h1, 10'd30,   32'hB1,       32'h88,       0, 32'h77,       0, 1, 16'd2);
      tbl[27] = mk(0, 1, 4'h0, 10'd30,   32'h0,        0, 4'h0, 10'd0,    32'h0,        32'hA1,       1, 32'hB1,       1, 0, 16'd2);
      tbl[28] = mk(0, 0, 4'h0, 10'd0,    32'h0,        0, 4'h0, 10'd0,    32'h0,        32'hA1,       1, 32'hB1,       0, 0, 16'd2);
      tbl[29] = mk(1, 1, 4'h0, 10'd30,   32'h0,        0, 4'h0, 10'd0,    32'h0,        32'h0,        0, 32'h0,        0, 0, 16'd0);
      tbl[30] = mk(0, 0, 4'h0, 10'd0,    32'h0,        0, 4'h0, 10'd0,    32'h0,        32'h0,        0, 32'h0,        0, 0, 16'd0);

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].rst, tbl[i].ena, tbl[i].wea, tbl[i].adra, tbl[i].dina,
               tbl[i].enb, tbl[i].web, tbl[i].adrb, tbl[i].dinb);
         tick();
         chk($sformatf("v%0d douta", i),   douta_wf,        tbl[i].xa);
         chk($sformatf("v%0d dvalida", i), 32'(dva_wf),     32'(tbl[i].va));
         chk($sformatf("v%0d doutb", i),   doutb_wf,        tbl[i].xb);
         chk($sformatf("v%0d dvalidb", i), 32'(dvb_wf),     32'(tbl[i].vb));
         chk($sformatf("v%0d coll_o", i),  32'(coll_wf),    32'(tbl[i].xc));
         chk($sformatf("v%0d coll_cnt", i), 32'(cnt_wf),    32'(CNT_EN ? tbl[i].xn : 16'd0));
      end

      // Read-during-write on each RDW mode; @3 starts at zero, @12 holds 5.
      drive(0, 1, 4'h0, 10'd12, 32'h0, 0, 4'h0, 10'd0, 32'h0);
      tick();
      chk("nc pre douta", douta_nc, 32'h5);
      chk("nc pre dvalida", 32'(dva_nc), 32'd1);
      drive(0, 1, 4'hF, 10'd3, 32'h1, 0, 4'h0, 10'd0, 32'h0);
      tick();
      chk("nc wr1 douta held", douta_nc, 32'h5);
      chk("nc wr1 dvalida", 32'(dva_nc), 32'd0);
      drive(0, 1, 4'hF, 10'd3, 32'h2, 0, 4'h0, 10'd0, 32'h0);
      tick();
      chk("nc wr2 douta held", douta_nc, 32'h5);
      chk("nc wr2 dvalida", 32'(dva_nc), 32'd0);
      chk("wf rdw1 douta", douta_wf, 32'h1);
      chk("wf rdw1 dvalida", 32'(dva_wf), 32'd1);
      chk("rf pre douta", douta_rf, 32'h5);
      drive(0, 1, 4'h0, 10'd3, 32'h0, 0, 4'h0, 10'd0, 32'h0);
      tick();
      chk("nc rd douta", douta_nc, 32'h2);
      chk("nc rd dvalida", 32'(dva_nc), 32'd1);
      chk("wf rdw2 douta", douta_wf, 32'h2);
      chk("rf rdw0 douta", douta_rf, 32'h0);
      chk("rf rdw0 dvalida", 32'(dva_rf), 32'd1);
      drive(0, 0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd0, 32'h0);
      tick();
      chk("wf rd3 douta", douta_wf, 32'h2);
      chk("rf rdw2 douta", douta_rf, 32'h1);
      chk("rf rdw2 dvalida", 32'(dva_rf), 32'd1);
      tick();
      chk("rf rd3 douta", douta_rf, 32'h2);
      chk("rf rd3 dvalida", 32'(dva_rf), 32'd1);

      // Reset lands on the second of three back-to-back reads on the 2-stage instance.
      drive(0, 1, 4'h0, 10'd3, 32'h0, 0, 4'h0, 10'd0, 32'h0);
      tick();
      for (int c = 0; c < 5; c++) begin
         if (c < 2) drive(1, 1, 4'h0, 10'd3, 32'h0, 0, 4'h0, 10'd0, 32'h0);
         else       drive(0, 0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd0, 32'h0);
         tick();
         chk($sformatf("rst c%0d rf douta", c), douta_rf, 32'h0);
         chk($sformatf("rst c%0d rf dvalida", c), 32'(dva_rf), 32'd0);
      end
      drive(0, 1, 4'h0, 10'd3, 32'h0, 0, 4'h0, 10'd0, 32'h0);
      tick();
      drive(0, 0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd0, 32'h0);
      tick();
      chk("retain wf douta", douta_wf, 32'h2);
      chk("retain rf dvalida early", 32'(dva_rf), 32'd0);
      tick();
      chk("retain rf douta", douta_rf, 32'h2);
      chk("retain rf dvalida", 32'(dva_rf), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
